// File: rtl/keygate_array_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : keygate_array_seq                                             |
// | Description : XOR and 4:1 mux key-gates driven by a serially loaded,        |
// |               atomically committed key. Optional KEYGATE_SOUT_EN adds a     |
// |               shift-style load with a key_sout daisy-chain output.          |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module keygate_array_seq #(
    parameter int N_XOR = 25,
    parameter int N_MUX = 1,
    parameter int PIPE  = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  key_start,
    input  logic                                  key_valid,
    input  logic                                  key_bit,
    output logic                                  key_ready,
    output logic                                  key_done,
    output logic                                  key_locked,
    output logic                                  key_err,
`ifdef KEYGATE_SOUT_EN
    output logic                                  key_sout,
`endif
    input  logic [N_XOR-1:0]                      xor_in,
    output logic [N_XOR-1:0]                      xor_out,
    input  logic [((N_MUX > 0) ? N_MUX : 1)-1:0] mux_a,
    input  logic [((N_MUX > 0) ? N_MUX : 1)-1:0] mux_b,
    output logic [((N_MUX > 0) ? N_MUX : 1)-1:0] mux_out
);

    localparam int c_KEY_W  = N_XOR + 4 * N_MUX;
    localparam int c_CNT_W  = $clog2(c_KEY_W + 1);
    localparam int c_MUX_PW = (N_MUX > 0) ? N_MUX : 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SHIFT  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;
    localparam logic [1:0] c_ST_ACTIVE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_KEY_W-1:0] r_shadow;
    logic [c_KEY_W-1:0] r_akey;
    logic [c_KEY_W-1:0] w_gate_key;
    logic               r_locked;
    logic               r_err;
    logic               w_accept;
    logic               w_last;
    logic [N_XOR-1:0]   w_xor;
    logic [c_MUX_PW-1:0] w_mux;

    assign w_last     = (r_cnt == c_CNT_W'(c_KEY_W - 1));
    assign key_locked = r_locked;
    assign key_err    = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // A restart in SHIFT takes priority over a bit presented in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        key_ready   = 1'b0;
        key_done    = 1'b0;
        case (r_state)
            c_ST_IDLE:   if (key_start) w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT: begin
                key_ready = 1'b1;
                w_accept  = key_valid && !key_start;
                if (w_accept && w_last) w_state_nxt = c_ST_COMMIT;
            end
            c_ST_COMMIT: begin
                key_done    = 1'b1;
                w_state_nxt = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: if (key_start) w_state_nxt = c_ST_SHIFT;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_shadow <= '0;
            r_akey   <= '0;
            r_locked <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (key_start && r_state == c_ST_SHIFT) begin
                r_err <= 1'b1;
                r_cnt <= '0;
            end else if (key_start && (r_state == c_ST_IDLE || r_state == c_ST_ACTIVE)) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
`ifdef KEYGATE_SOUT_EN
                r_shadow <= (r_shadow << 1) | c_KEY_W'(key_bit);
`else
                for (int i = 0; i < c_KEY_W; i++) begin
                    if (r_cnt == c_CNT_W'(i)) r_shadow[i] <= key_bit;
                end
`endif
            end
            if (r_state == c_ST_COMMIT) begin
                r_akey   <= r_shadow;
                r_locked <= 1'b1;
            end
        end
    end

`ifdef KEYGATE_SOUT_EN
    assign key_sout = r_shadow[c_KEY_W-1];
`endif

    // Registered outputs pick up the committing key so it shows right after COMMIT.
    assign w_gate_key = (PIPE != 0 && r_state == c_ST_COMMIT) ? r_shadow : r_akey;
    assign w_xor      = xor_in ^ w_gate_key[N_XOR-1:0];

    generate
        if (N_MUX > 0) begin : g_mux
            for (genvar gi = 0; gi < N_MUX; gi++) begin : g_gate
                logic [3:0] w_k;
                assign w_k        = w_gate_key[N_XOR + 4*gi +: 4];
                assign w_mux[gi]  = w_k[{mux_b[gi], mux_a[gi]}];
            end
        end else begin : g_no_mux
            assign w_mux = '0;
        end

        if (PIPE != 0) begin : g_pipe
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    xor_out <= '0;
                    mux_out <= '0;
                end else begin
                    xor_out <= w_xor;
                    mux_out <= w_mux;
                end
            end
        end else begin : g_comb
            assign xor_out = w_xor;
            assign mux_out = w_mux;
        end
    endgenerate

endmodule
`default_nettype wire
